alu_cmd_sequencer: RTL and testbench

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_cmd_fifo.sv | 62 ++++++
 rtl/alu_cmd_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Holds the opcode map, the command payload layout and the FSM state encoding.
package alu_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned OPP_W  = 3;

    localparam logic [OPP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [OPP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [OPP_W-1:0] ALU_AND = 3'b010;
    localparam logic [OPP_W-1:0] ALU_OR  = 3'b011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } seq_state_t;

    // One queued command, {a,b,opp,cin} = 12 bits.
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OPP_W-1:0]  opp;
        logic              cin;
    } alu_cmd_t;

    localparam int unsigned CMD_W = $bits(alu_cmd_t);

    function automatic logic opp_is_legal(input logic [OPP_W-1:0] opp);
        return (opp == ALU_ADD) || (opp == ALU_SUB) || (opp == ALU_AND) || (opp == ALU_OR);
    endfunction

    // Only arithmetic ops produce meaningful overflow/carry; logic ops leave them floating.
    function automatic logic opp_has_flags(input logic [OPP_W-1:0] opp);
        return (opp == ALU_ADD) || (opp == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: DEPTH entries (power of 2), registered occupancy, pointers wrap modulo DEPTH.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  alu_cmd_t din,
    input  logic     pop,
    output alu_cmd_t head,
    output logic     full,
    output logic     empty,
    output logic     one_left
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    alu_cmd_t       mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           do_push;
    logic           do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign one_left = (count == CW'(1));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head     = mem[rd_ptr];

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, issues them to an external combinational 4-bit ALU and registers results.
// Optional sticky overflow/carry flags are built only when ALU_SEQ_STICKY_FLAGS_EN is defined.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmdValid,
    output logic              cmdReady,
    input  logic [DATA_W-1:0] cmdA,
    input  logic [DATA_W-1:0] cmdB,
    input  logic [OPP_W-1:0]  cmdOpp,
    input  logic              cmdCin,
    output logic [DATA_W-1:0] aluA,
    output logic [DATA_W-1:0] aluB,
    output logic [OPP_W-1:0]  aluOpp,
    output logic              aluCin,
    input  logic [DATA_W-1:0] aluResult,
    input  logic              aluOverFlow,
    input  logic              aluCarrout,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] outResult,
    output logic              outOverFlow,
    output logic              outCarrout,
    output logic              outZero,
    output logic              outIllegal,
    input  logic              clrSticky,
    output logic              stickyOverFlow,
    output logic              stickyCarry
);

    seq_state_t         state;
    seq_state_t         state_next;
    alu_cmd_t           cmd_in;
    alu_cmd_t           head;
    alu_cmd_t           last_cmd;
    alu_cmd_t           alu_cmd;
    logic               full;
    logic               empty;
    logic               one_left;
    logic               push;
    logic               capture;
    logic               out_free;
    logic [DATA_W-1:0]  cap_result;
    logic               cap_ovf;
    logic               cap_carry;
    logic               cap_illegal;

    assign cmd_in   = '{a: cmdA, b: cmdB, opp: cmdOpp, cin: cmdCin};
    assign cmdReady = !full;
    assign push     = cmdValid && !full;
    assign out_free = !outValid || outReady;

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .din      (cmd_in),
        .pop      (capture),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .one_left (one_left)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture happens only in ISSUE with a free output slot; the pop rides on it.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (out_free) begin
                    capture = 1'b1;
                    if (!outReady) begin
                        state_next = HOLD;
                    end else if (one_left && !push) begin
                        state_next = IDLE;
                    end
                end
            end
            HOLD: begin
                if (outReady) begin
                    state_next = empty ? IDLE : ISSUE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The ALU sees the FIFO head while issuing and the last issued command otherwise.
    assign alu_cmd = (state == ISSUE) ? head : last_cmd;
    assign aluA    = alu_cmd.a;
    assign aluB    = alu_cmd.b;
    assign aluOpp  = alu_cmd.opp;
    assign aluCin  = alu_cmd.cin;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_cmd <= '0;
        end else if (state == ISSUE) begin
            last_cmd <= head;
        end
    end

    // Sanitise the ALU response: illegal ops are zeroed, logic ops drop the floating flags.
    always_comb begin
        cap_result  = '0;
        cap_ovf     = 1'b0;
        cap_carry   = 1'b0;
        cap_illegal = 1'b1;
        if (opp_is_legal(alu_cmd.opp)) begin
            cap_illegal = 1'b0;
            cap_result  = aluResult;
            if (opp_has_flags(alu_cmd.opp)) begin
                cap_ovf   = aluOverFlow;
                cap_carry = aluCarrout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outValid    <= 1'b0;
            outResult   <= '0;
            outOverFlow <= 1'b0;
            outCarrout  <= 1'b0;
            outZero     <= 1'b0;
            outIllegal  <= 1'b0;
        end else if (capture) begin
            outValid    <= 1'b1;
            outResult   <= cap_result;
            outOverFlow <= cap_ovf;
            outCarrout  <= cap_carry;
            outZero     <= (cap_result == '0) && !cap_illegal;
            outIllegal  <= cap_illegal;
        end else if (outValid && outReady) begin
            outValid    <= 1'b0;
        end
    end

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    logic sticky_ovf_q;
    logic sticky_carry_q;

    // Clear wins over a same-cycle capture.
    always_ff @(posedge clk) begin
        if (reset || clrSticky) begin
            sticky_ovf_q   <= 1'b0;
            sticky_carry_q <= 1'b0;
        end else if (capture) begin
            sticky_ovf_q   <= sticky_ovf_q | cap_ovf;
            sticky_carry_q <= sticky_carry_q | cap_carry;
        end
    end

    assign stickyOverFlow = sticky_ovf_q;
    assign stickyCarry    = sticky_carry_q;
`else
    logic unused_clr_sticky;

    assign unused_clr_sticky = clrSticky;
    assign stickyOverFlow    = 1'b0;
    assign stickyCarry       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a behavioural 4-bit ALU in the loop.
module tb_alu_cmd_sequencer;

    logic       clk;
    logic       reset;
    logic       cmdValid;
    logic       cmdReady;
    logic [3:0] cmdA;
    logic [3:0] cmdB;
    logic [2:0] cmdOpp;
    logic       cmdCin;
    logic [3:0] aluA;
    logic [3:0] aluB;
    logic [2:0] aluOpp;
    logic       aluCin;
    logic [3:0] aluResult;
    logic       aluOverFlow;
    logic       aluCarrout;
    logic       outValid;
    logic       outReady;
    logic [3:0] outResult;
    logic       outOverFlow;
    logic       outCarrout;
    logic       outZero;
    logic       outIllegal;
    logic       clrSticky;
    logic       stickyOverFlow;
    logic       stickyCarry;

    int checks = 0;
    int errors = 0;

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif

    alu_cmd_sequencer #(.DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmdValid       (cmdValid),
        .cmdReady       (cmdReady),
        .cmdA           (cmdA),
        .cmdB           (cmdB),
        .cmdOpp         (cmdOpp),
        .cmdCin         (cmdCin),
        .aluA           (aluA),
        .aluB           (aluB),
        .aluOpp         (aluOpp),
        .aluCin         (aluCin),
        .aluResult      (aluResult),
        .aluOverFlow    (aluOverFlow),
        .aluCarrout     (aluCarrout),
        .outValid       (outValid),
        .outReady       (outReady),
        .outResult      (outResult),
        .outOverFlow    (outOverFlow),
        .outCarrout     (outCarrout),
        .outZero        (outZero),
        .outIllegal     (outIllegal),
        .clrSticky      (clrSticky),
        .stickyOverFlow (stickyOverFlow),
        .stickyCarry    (stickyCarry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; non-arithmetic ops drive 1 on the flags so any leak is visible.
    logic [4:0] sum;
    always_comb begin
        sum         = '0;
        aluResult   = '0;
        aluOverFlow = 1'b0;
        aluCarrout  = 1'b0;
        case (aluOpp)
            3'b000: begin
                sum         = {1'b0, aluA} + {1'b0, aluB} + {4'b0, aluCin};
                aluResult   = sum[3:0];
                aluCarrout  = sum[4];
                aluOverFlow = (aluA[3] == aluB[3]) && (sum[3] != aluA[3]);
            end
            3'b001: begin
                sum         = {1'b0, aluA} + {1'b0, ~aluB} + {4'b0, aluCin};
                aluResult   = sum[3:0];
                aluCarrout  = sum[4];
                aluOverFlow = (aluA[3] != aluB[3]) && (sum[3] != aluA[3]);
            end
            3'b010: begin
                aluResult   = aluA & aluB;
                aluOverFlow = 1'b1;
                aluCarrout  = 1'b1;
            end
            3'b011: begin
                aluResult   = aluA | aluB;
                aluOverFlow = 1'b1;
                aluCarrout  = 1'b1;
            end
            default: begin
                aluResult   = aluA ^ aluB;
                aluOverFlow = 1'b1;
                aluCarrout  = 1'b1;
            end
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input logic [3:0] a, input logic [3:0] b,
                            input logic [2:0] opp, input logic cin);
        cmdA     = a;
        cmdB     = b;
        cmdOpp   = opp;
        cmdCin   = cin;
        cmdValid = 1'b1;
        tick();
        cmdValid = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] res, input logic ovf,
                           input logic cry, input logic zero, input logic ill);
        chk1({tag, "_valid"}, outValid, 1'b1);
        chk4({tag, "_result"}, outResult, res);
        chk1({tag, "_ovf"}, outOverFlow, ovf);
        chk1({tag, "_carry"}, outCarrout, cry);
        chk1({tag, "_zero"}, outZero, zero);
        chk1({tag, "_illegal"}, outIllegal, ill);
    endtask

    logic [3:0] got[$];
    logic [3:0] exp_q[5];
    logic       stale;

    initial begin
        reset     = 1'b1;
        cmdValid  = 1'b0;
        cmdA      = '0;
        cmdB      = '0;
        cmdOpp    = '0;
        cmdCin    = 1'b0;
        outReady  = 1'b1;
        clrSticky = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk1("rst_cmdReady", cmdReady, 1'b1);
        chk1("rst_outValid", outValid, 1'b0);
        chk4("rst_outResult", outResult, 4'h0);
        chk4("rst_aluA", aluA, 4'h0);
        chk1("rst_stickyOvf", stickyOverFlow, 1'b0);

        // Single add 0111+0001: two-edge latency
        push_cmd(4'b0111, 4'b0001, 3'b000, 1'b0);
        chk1("add_lat1", outValid, 1'b0);
        tick();
        chk1("add_lat2", outValid, 1'b0);
        chk4("add_issue_aluA", aluA, 4'b0111);
        tick();
        chk_out("add", 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk1("add_clear", outValid, 1'b0);
        chk4("add_hold_aluA", aluA, 4'b0111);

        // Subtract 5-3 with cin=1
        push_cmd(4'd5, 4'd3, 3'b001, 1'b1);
        tick();
        tick();
        chk_out("sub", 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();

        // Illegal opcode 101
        push_cmd(4'd3, 4'd4, 3'b101, 1'b0);
        tick();
        tick();
        chk_out("illegal", 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();

        // AND to zero, flags masked
        push_cmd(4'b1010, 4'b0101, 3'b010, 1'b0);
        tick();
        tick();
        chk_out("and", 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();

        // OR
        push_cmd(4'b1010, 4'b0101, 3'b011, 1'b0);
        tick();
        tick();
        chk_out("or", 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();

        // Backpressure: five pushes with outReady=0
        outReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_q[i] = 4'(i + 3);
            push_cmd(4'(i + 1), 4'd2, 3'b000, 1'b0);
        end
        chk1("bp_full_cmdReady", cmdReady, 1'b0);
        chk1("bp_first_valid", outValid, 1'b1);
        chk4("bp_first_result", outResult, 4'd3);
        cmdA     = 4'hF;
        cmdB     = 4'hF;
        cmdOpp   = 3'b000;
        cmdValid = 1'b1;
        tick();
        tick();
        cmdValid = 1'b0;
        chk1("bp_still_full", cmdReady, 1'b0);
        chk1("bp_held_valid", outValid, 1'b1);
        chk4("bp_held_result", outResult, 4'd3);
        outReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (outValid) got.push_back(outResult);
            tick();
        end
        chk4("bp_count", 4'(got.size()), 4'd5);
        for (int i = 0; i < 5; i++) begin
            chk4($sformatf("bp_result%0d", i), (i < got.size()) ? got[i] : 4'hx, exp_q[i]);
        end
        chk1("bp_drained_ready", cmdReady, 1'b1);

        // Reset mid-burst
        outReady = 1'b0;
        push_cmd(4'd9, 4'd0, 3'b000, 1'b0);
        push_cmd(4'd8, 4'd0, 3'b000, 1'b0);
        push_cmd(4'd7, 4'd0, 3'b000, 1'b0);
        chk1("mid_valid_before", outValid, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk1("mid_rst_valid", outValid, 1'b0);
        chk1("mid_rst_ready", cmdReady, 1'b1);
        chk4("mid_rst_result", outResult, 4'h0);
        chk4("mid_rst_aluA", aluA, 4'h0);
        outReady = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (outValid) stale = 1'b1;
            tick();
        end
        chk1("mid_no_stale", stale, 1'b0);
        push_cmd(4'd0, 4'd0, 3'b000, 1'b0);
        tick();
        tick();
        chk_out("post_rst_add", 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk1("post_rst_stickyOvf", stickyOverFlow, 1'b0);
        tick();

        // Sticky flags
        push_cmd(4'b0111, 4'b0001, 3'b000, 1'b0);
        tick();
        tick();
        chk1("stk_ovf_set", stickyOverFlow, STK);
        chk1("stk_carry_clear", stickyCarry, 1'b0);
        tick();
        push_cmd(4'd1, 4'd2, 3'b011, 1'b0);
        tick();
        tick();
        chk4("stk_or_result", outResult, 4'd3);
        chk1("stk_ovf_kept", stickyOverFlow, STK);
        clrSticky = 1'b1;
        tick();
        clrSticky = 1'b0;
        chk1("stk_ovf_cleared", stickyOverFlow, 1'b0);
        push_cmd(4'hF, 4'h1, 3'b000, 1'b0);
        tick();
        clrSticky = 1'b1;
        tick();
        clrSticky = 1'b0;
        chk_out("stk_prio_add", 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk1("stk_clr_priority", stickyCarry, 1'b0);
        tick();
        push_cmd(4'hF, 4'h1, 3'b000, 1'b0);
        tick();
        tick();
        chk1("stk_carry_set", stickyCarry, STK);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
